// File: rtl/ptw_sv39_pkg.sv
// Shared Sv39 definitions for the page-table walker: PTE layout, walk states,
// page-level encoding and small field-extraction helpers.
package ptw_sv39_pkg;

   localparam int unsigned PADDR_W   = 56;
   localparam int unsigned PPN_W     = 44;
   localparam int unsigned VPN_W     = 27;
   localparam int unsigned VPN_SEG_W = 9;
   localparam int unsigned PTE_W     = 64;
   localparam int unsigned FLAGS_W   = 10;
   localparam int unsigned LEVEL_W   = 2;
   localparam int unsigned RSVD_W    = 10;

   // PTE flag bit positions
   localparam int unsigned BIT_V = 0;
   localparam int unsigned BIT_R = 1;
   localparam int unsigned BIT_W = 2;
   localparam int unsigned BIT_X = 3;
   localparam int unsigned BIT_U = 4;
   localparam int unsigned BIT_G = 5;
   localparam int unsigned BIT_A = 6;
   localparam int unsigned BIT_D = 7;

   localparam int unsigned PTE_PPN_LSB  = 10;
   localparam int unsigned PTE_PPN_MSB  = 53;
   localparam int unsigned PTE_RSVD_LSB = 54;

   // Low PPN bits that must be zero for an aligned superpage leaf
   localparam int unsigned ALIGN_1G_W = 18;
   localparam int unsigned ALIGN_2M_W = 9;

   typedef logic [LEVEL_W-1:0] level_t;
   localparam level_t LVL_4K = 2'd0;
   localparam level_t LVL_2M = 2'd1;
   localparam level_t LVL_1G = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DONE,
      ST_DRAIN
   } walk_state_e;

   typedef struct packed {
      logic               err;
      level_t             level;
      logic [PPN_W-1:0]   ppn;
      logic [FLAGS_W-1:0] pte;
   } walk_resp_t;

   function automatic logic [PPN_W-1:0] pte_ppn(input logic [PTE_W-1:0] pte);
      return pte[PTE_PPN_MSB:PTE_PPN_LSB];
   endfunction

   function automatic logic [RSVD_W-1:0] pte_rsvd(input logic [PTE_W-1:0] pte);
      return pte[PTE_W-1:PTE_RSVD_LSB];
   endfunction

   function automatic logic [VPN_SEG_W-1:0] vpn_seg(input logic [VPN_W-1:0] vpn,
                                                    input level_t lvl);
      case (lvl)
         LVL_1G:  return vpn[26:18];
         LVL_2M:  return vpn[17:9];
         default: return vpn[8:0];
      endcase
   endfunction

endpackage

// File: rtl/ptw_pte_check.sv
// Combinational classification of one fetched PTE into fault, valid leaf or
// pointer to the next table level.
module ptw_pte_check
   import ptw_sv39_pkg::*;
(
   input  logic [PTE_W-1:0] pte,
   input  level_t           level,
   input  logic             err,
   output logic             fault_c,
   output logic             leaf_c,
   output logic             next_c
);

   logic v, r, w, x;
   logic bad_enc, is_leaf, misaligned;
   logic unused_pte;

   // Only the flag, reserved and low-PPN alignment bits matter here
   assign unused_pte = ^{pte[PTE_PPN_MSB:PTE_PPN_LSB+ALIGN_1G_W], pte[FLAGS_W-1:BIT_U]};

   always_comb begin
      v          = pte[BIT_V];
      r          = pte[BIT_R];
      w          = pte[BIT_W];
      x          = pte[BIT_X];
      bad_enc    = err | ~v | (~r & w) | (pte_rsvd(pte) != '0);
      is_leaf    = r | x;
      misaligned = 1'b0;
      fault_c    = 1'b0;
      leaf_c     = 1'b0;
      next_c     = 1'b0;

      if (level == LVL_1G) begin
         misaligned = (pte[PTE_PPN_LSB +: ALIGN_1G_W] != '0);
      end else if (level == LVL_2M) begin
         misaligned = (pte[PTE_PPN_LSB +: ALIGN_2M_W] != '0);
      end

      if (bad_enc) begin
         fault_c = 1'b1;
      end else if (is_leaf) begin
         if (misaligned) fault_c = 1'b1;
         else            leaf_c  = 1'b1;
      end else if (level == LVL_4K) begin
         fault_c = 1'b1;
      end else begin
         next_c = 1'b1;
      end
   end

endmodule

// File: rtl/ptw_sv39.sv
// Sv39 hardware page-table walker: fetches up to three PTEs on a TLB miss and
// returns the leaf flags/PPN/level or a walk fault. One memory read in flight.
module ptw_sv39
   import ptw_sv39_pkg::*;
(
   input  logic               clk_i,
   input  logic               srst_i,
   input  logic               flush_i,
   input  logic [PPN_W-1:0]   satp_ppn_i,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic [VPN_W-1:0]   req_vpn_i,
   output logic               mem_valid_o,
   input  logic               mem_ready_i,
   output logic [PADDR_W-1:0] mem_addr_o,
   input  logic               mem_rvalid_i,
   input  logic [PTE_W-1:0]   mem_rdata_i,
   input  logic               mem_err_i,
   output logic               resp_valid_o,
   input  logic               resp_ready_i,
   output logic [FLAGS_W-1:0] resp_pte_o,
   output logic [PPN_W-1:0]   resp_ppn_o,
   output logic [LEVEL_W-1:0] resp_level_o,
   output logic               resp_err_o
);

   walk_state_e        state_q, state_d;
   logic [VPN_W-1:0]   vpn_q, vpn_d;
   logic [PPN_W-1:0]   base_q, base_d;
   level_t             level_q, level_d;
   logic               req_ready_d, mem_valid_d, resp_valid_d;
   logic [PADDR_W-1:0] addr_d;
   walk_resp_t         resp_q, resp_d;
   logic               fault_c, leaf_c, next_c;

   ptw_pte_check u_pte_check (
      .pte     (mem_rdata_i),
      .level   (level_q),
      .err     (mem_err_i),
      .fault_c (fault_c),
      .leaf_c  (leaf_c),
      .next_c  (next_c)
   );

   assign resp_pte_o   = resp_q.pte;
   assign resp_ppn_o   = resp_q.ppn;
   assign resp_level_o = resp_q.level;
   assign resp_err_o   = resp_q.err;

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q      <= ST_IDLE;
         vpn_q        <= '0;
         base_q       <= '0;
         level_q      <= LVL_1G;
         req_ready_o  <= 1'b1;
         mem_valid_o  <= 1'b0;
         mem_addr_o   <= '0;
         resp_valid_o <= 1'b0;
         resp_q       <= '0;
      end else begin
         state_q      <= state_d;
         vpn_q        <= vpn_d;
         base_q       <= base_d;
         level_q      <= level_d;
         req_ready_o  <= req_ready_d;
         mem_valid_o  <= mem_valid_d;
         mem_addr_o   <= addr_d;
         resp_valid_o <= resp_valid_d;
         resp_q       <= resp_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      vpn_d        = vpn_q;
      base_d       = base_q;
      level_d      = level_q;
      addr_d       = mem_addr_o;
      resp_d       = resp_q;
      req_ready_d  = 1'b0;
      mem_valid_d  = 1'b0;
      resp_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!flush_i && req_valid_i && req_ready_o) begin
               vpn_d   = req_vpn_i;
               base_d  = satp_ppn_i;
               level_d = LVL_1G;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            // An accepted read must still be drained; an unaccepted one is withdrawn
            if (flush_i)          state_d = mem_ready_i ? ST_DRAIN : ST_IDLE;
            else if (mem_ready_i) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (flush_i) begin
               state_d = mem_rvalid_i ? ST_IDLE : ST_DRAIN;
            end else if (mem_rvalid_i) begin
               if (fault_c) begin
                  resp_d  = '{err: 1'b1, level: level_q, ppn: '0, pte: '0};
                  state_d = ST_DONE;
               end else if (leaf_c) begin
                  resp_d  = '{err: 1'b0, level: level_q, ppn: pte_ppn(mem_rdata_i),
                              pte: mem_rdata_i[FLAGS_W-1:0]};
                  state_d = ST_DONE;
               end else if (next_c) begin
                  base_d  = pte_ppn(mem_rdata_i);
                  level_d = level_q - 2'd1;
                  state_d = ST_REQ;
               end
            end
         end
         ST_DONE: begin
            if (flush_i || resp_ready_i) state_d = ST_IDLE;
         end
         ST_DRAIN: begin
            if (mem_rvalid_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Registered outputs track the state being entered
      req_ready_d  = (state_d == ST_IDLE);
      mem_valid_d  = (state_d == ST_REQ);
      resp_valid_d = (state_d == ST_DONE);
      if (state_d == ST_REQ) begin
         addr_d = {base_d, vpn_seg(vpn_d, level_d), 3'b000};
      end
   end

endmodule

// File: tb/tb_ptw_sv39.sv
// Self-checking bench for ptw_sv39: table of walks against a scripted PTE
// memory, plus hand sequences for flush, backpressure and mid-walk reset.
module tb_ptw_sv39;

   logic        clk_i = 1'b0;
   logic        srst_i;
   logic        flush_i;
   logic [43:0] satp_ppn_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [26:0] req_vpn_i;
   logic        mem_valid_o;
   logic        mem_ready_i;
   logic [55:0] mem_addr_o;
   logic        mem_rvalid_i;
   logic [63:0] mem_rdata_i;
   logic        mem_err_i;
   logic        resp_valid_o;
   logic        resp_ready_i;
   logic [9:0]  resp_pte_o;
   logic [43:0] resp_ppn_o;
   logic [1:0]  resp_level_o;
   logic        resp_err_o;

   ptw_sv39 dut (
      .clk_i        (clk_i),
      .srst_i       (srst_i),
      .flush_i      (flush_i),
      .satp_ppn_i   (satp_ppn_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_vpn_i    (req_vpn_i),
      .mem_valid_o  (mem_valid_o),
      .mem_ready_i  (mem_ready_i),
      .mem_addr_o   (mem_addr_o),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .mem_err_i    (mem_err_i),
      .resp_valid_o (resp_valid_o),
      .resp_ready_i (resp_ready_i),
      .resp_pte_o   (resp_pte_o),
      .resp_ppn_o   (resp_ppn_o),
      .resp_level_o (resp_level_o),
      .resp_err_o   (resp_err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        err;
      logic [1:0]  level;
      logic [43:0] ppn;
      logic [9:0]  pte;
      int          nrd;
      int          lat;
   } exp_t;

   typedef struct {
      logic [43:0] satp;
      logic [26:0] vpn;
      logic [63:0] p0, p1, p2;
      int          nrd;
      int          err_rd;
      logic        err;
      logic [1:0]  level;
      logic [43:0] ppn;
      logic [9:0]  pte;
   } vec_t;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int t0 = 0;
   int rd_cnt = 0;
   int rd_base = 0;
   int done_cnt = 0;
   int mem_delay = 0;
   int bp_cycles = 0;
   string cur_tag = "reset";

   exp_t        exp_q[$];
   logic [55:0] addr_q[$];
   logic [63:0] pte_q[$];
   logic        err_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   function automatic logic [8:0] seg(input logic [26:0] vpn, input int lvl);
      logic [26:0] s;
      s = vpn >> (9 * lvl);
      return s[8:0];
   endfunction

   always @(posedge clk_i) cyc++;

   // Scripted PTE memory: checks each read address, returns data mem_delay cycles later
   logic        pend = 1'b0;
   int          pend_cnt = 0;
   logic [63:0] pend_data;
   logic        pend_err;
   always @(negedge clk_i) begin
      mem_rvalid_i = 1'b0;
      mem_err_i    = 1'b0;
      mem_rdata_i  = '0;
      if (pend) begin
         if (pend_cnt == 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = pend_data;
            mem_err_i    = pend_err;
            pend         = 1'b0;
         end else begin
            pend_cnt--;
         end
      end
      if (mem_valid_o && mem_ready_i) begin
         if (pend) fail_now({cur_tag, "_second_outstanding_read"});
         if (addr_q.size() == 0) fail_now({cur_tag, "_unexpected_read"});
         else check({cur_tag, "_mem_addr"}, 64'(mem_addr_o), 64'(addr_q.pop_front()));
         pend      = 1'b1;
         pend_cnt  = mem_delay;
         pend_data = (pte_q.size() != 0) ? pte_q.pop_front() : 64'h0;
         pend_err  = (err_q.size() != 0) ? err_q.pop_front() : 1'b0;
         rd_cnt++;
      end
   end

   // Response monitor: backpressure, stability, scoreboard compare on handshake
   logic        seen = 1'b0;
   logic        after_hs = 1'b0;
   int          hold_cnt = 0;
   int          lat_meas = 0;
   logic [63:0] cap;
   exp_t        e_mon;
   always @(negedge clk_i) begin
      if (after_hs) begin
         check({cur_tag, "_idle_after_resp"}, 64'({resp_valid_o, req_ready_o}), 64'b01);
         after_hs = 1'b0;
      end
      resp_ready_i = 1'b0;
      if (resp_valid_o) begin
         if (!seen) begin
            seen     = 1'b1;
            lat_meas = cyc - t0 + 1;
            hold_cnt = bp_cycles;
            cap      = 64'({resp_err_o, resp_level_o, resp_ppn_o, resp_pte_o});
         end else begin
            check({cur_tag, "_resp_stable"},
                  64'({resp_err_o, resp_level_o, resp_ppn_o, resp_pte_o}), cap);
         end
         if (hold_cnt > 0) begin
            check({cur_tag, "_bp_req_ready"}, 64'(req_ready_o), 64'd0);
            check({cur_tag, "_bp_mem_valid"}, 64'(mem_valid_o), 64'd0);
            hold_cnt--;
         end else begin
            resp_ready_i = 1'b1;
            seen         = 1'b0;
            after_hs     = 1'b1;
            if (exp_q.size() == 0) begin
               fail_now({cur_tag, "_spurious_resp"});
            end else begin
               e_mon = exp_q.pop_front();
               check({cur_tag, "_err"},   64'(resp_err_o),   64'(e_mon.err));
               check({cur_tag, "_level"}, 64'(resp_level_o), 64'(e_mon.level));
               check({cur_tag, "_ppn"},   64'(resp_ppn_o),   64'(e_mon.ppn));
               check({cur_tag, "_pte"},   64'(resp_pte_o),   64'(e_mon.pte));
               check({cur_tag, "_reads"}, 64'(rd_cnt - rd_base), 64'(e_mon.nrd));
               if (e_mon.lat != 0) check({cur_tag, "_latency"}, 64'(lat_meas), 64'(e_mon.lat));
            end
            done_cnt++;
         end
      end
   end

   // Launch one walk: script memory, push expectations, wait for the response
   task automatic run_walk(input vec_t v, input bit lat_chk);
      logic [63:0] p[3];
      logic [43:0] base;
      exp_t        e;
      int          d0, k;
      p[0] = v.p0; p[1] = v.p1; p[2] = v.p2;
      base = v.satp;
      for (int i = 0; i < v.nrd; i++) begin
         addr_q.push_back({base, seg(v.vpn, 2 - i), 3'b000});
         pte_q.push_back(p[i]);
         err_q.push_back(i == v.err_rd);
         base = p[i][53:10];
      end
      e = '{v.err, v.level, v.ppn, v.pte, v.nrd, lat_chk ? 1 + 2 * v.nrd : 0};
      exp_q.push_back(e);
      d0 = done_cnt;
      @(negedge clk_i);
      satp_ppn_i  = v.satp;
      req_vpn_i   = v.vpn;
      req_valid_i = 1'b1;
      k = 0;
      while (!req_ready_o && k < 20) begin
         @(negedge clk_i);
         k++;
      end
      if (k == 20) fail_now({cur_tag, "_accept_timeout"});
      t0      = cyc + 1;
      rd_base = rd_cnt;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      k = 0;
      while (done_cnt == d0 && k < 200) begin
         @(posedge clk_i);
         k++;
      end
      if (k == 200) fail_now({cur_tag, "_resp_timeout"});
   endtask

   vec_t vec[13];
   int   n;

   initial begin
      srst_i       = 1'b1;
      flush_i      = 1'b0;
      satp_ppn_i   = '0;
      req_valid_i  = 1'b0;
      req_vpn_i    = '0;
      mem_ready_i  = 1'b1;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      mem_err_i    = 1'b0;
      resp_ready_i = 1'b0;

      //          satp      vpn         p0                    p1                    p2                    nrd erd err lvl ppn                pte
      vec[0]  = '{44'h80000, 27'h0001203, 64'h20000401,        64'h20000801,        64'h200030CF,        3, 9, 0, 0, 44'h8000C,        10'h0CF};
      vec[1]  = '{44'h80000, 27'h0001203, 64'h200000CF,        64'h0,               64'h0,               1, 9, 0, 2, 44'h80000,        10'h0CF};
      vec[2]  = '{44'h80000, 27'h0001203, 64'h200004CF,        64'h0,               64'h0,               1, 9, 1, 2, 44'h0,            10'h000};
      vec[3]  = '{44'h80000, 27'h0001203, 64'h0,               64'h0,               64'h0,               1, 9, 1, 2, 44'h0,            10'h000};
      vec[4]  = '{44'h80000, 27'h0001203, 64'h4,               64'h0,               64'h0,               1, 9, 1, 2, 44'h0,            10'h000};
      vec[5]  = '{44'h80000, 27'h0001203, 64'h5,               64'h0,               64'h0,               1, 9, 1, 2, 44'h0,            10'h000};
      vec[6]  = '{44'h80000, 27'h0001203, 64'hD,               64'h0,               64'h0,               1, 9, 1, 2, 44'h0,            10'h000};
      vec[7]  = '{44'h80000, 27'h0001203, 64'h0040_0000_200000CF, 64'h0,            64'h0,               1, 9, 1, 2, 44'h0,            10'h000};
      vec[8]  = '{44'h80000, 27'h0001203, 64'h20000401,        64'h20000801,        64'h20000C01,        3, 9, 1, 0, 44'h0,            10'h000};
      vec[9]  = '{44'h80000, 27'h0001203, 64'h20000401,        64'h200008CF,        64'h0,               2, 1, 1, 1, 44'h0,            10'h000};
      vec[10] = '{44'h80000, 27'h0001203, 64'h20000401,        64'h200800CF,        64'h0,               2, 9, 0, 1, 44'h80200,        10'h0CF};
      vec[11] = '{44'h80000, 27'h0001203, 64'h20000401,        64'h200804CF,        64'h0,               2, 9, 1, 1, 44'h0,            10'h000};
      vec[12] = '{44'h12345, 27'h7FFFFFF, 64'h20000401,        64'h20000801,        64'h003F_FFFF_FFFF_FC49, 3, 9, 0, 0, 44'hFFF_FFFF_FFFF, 10'h049};

      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      srst_i = 1'b0;
      check("reset_req_ready",  64'(req_ready_o),  64'd1);
      check("reset_mem_valid",  64'(mem_valid_o),  64'd0);
      check("reset_resp_valid", 64'(resp_valid_o), 64'd0);
      check("reset_resp", 64'({resp_err_o, resp_level_o, resp_ppn_o, resp_pte_o}), 64'd0);

      for (int i = 0; i < 13; i++) begin
         cur_tag = $sformatf("vec%0d", i);
         run_walk(vec[i], 1'b1);
      end

      // Result held under backpressure
      cur_tag   = "backpressure";
      bp_cycles = 5;
      run_walk(vec[0], 1'b1);
      bp_cycles = 0;

      // Flush while waiting for read data: drain, no response
      cur_tag   = "flush_wait";
      mem_delay = 3;
      addr_q.push_back({44'h80000, 9'h0, 3'b000});
      pte_q.push_back(64'h20000401);
      err_q.push_back(1'b0);
      @(negedge clk_i);
      satp_ppn_i  = 44'h80000;
      req_vpn_i   = 27'h0001203;
      req_valid_i = 1'b1;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      @(negedge clk_i);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      n = 0;
      while (!req_ready_o && n < 20) begin
         check("flush_wait_drain_mem_valid", 64'(mem_valid_o), 64'd0);
         @(negedge clk_i);
         n++;
      end
      check("flush_wait_drain_cycles", 64'(n), 64'd3);
      @(posedge clk_i);
      mem_delay = 0;
      cur_tag   = "after_flush";
      run_walk(vec[0], 1'b1);

      // Flush while the read is still unaccepted: withdraw, address held while stalled
      cur_tag     = "flush_req";
      mem_ready_i = 1'b0;
      @(negedge clk_i);
      satp_ppn_i  = 44'h80000;
      req_vpn_i   = 27'h0001203;
      req_valid_i = 1'b1;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("flush_req_mem_valid", 64'(mem_valid_o), 64'd1);
         check("flush_req_addr_stable", 64'(mem_addr_o), 64'h8000_0000);
         if (i < 2) @(negedge clk_i);
      end
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      check("flush_req_idle_ready", 64'(req_ready_o), 64'd1);
      check("flush_req_mem_valid_off", 64'(mem_valid_o), 64'd0);
      @(posedge clk_i);
      mem_ready_i = 1'b1;

      // Synchronous reset mid-walk; the stale read data must be ignored
      cur_tag   = "srst_mid";
      mem_delay = 4;
      addr_q.push_back({44'h80000, 9'h0, 3'b000});
      pte_q.push_back(64'h200000CF);
      err_q.push_back(1'b0);
      @(negedge clk_i);
      satp_ppn_i  = 44'h80000;
      req_vpn_i   = 27'h0001203;
      req_valid_i = 1'b1;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      @(negedge clk_i);
      srst_i = 1'b1;
      @(negedge clk_i);
      srst_i = 1'b0;
      check("srst_mid_req_ready",  64'(req_ready_o),  64'd1);
      check("srst_mid_mem_valid",  64'(mem_valid_o),  64'd0);
      check("srst_mid_resp_valid", 64'(resp_valid_o), 64'd0);
      repeat (6) @(negedge clk_i);
      @(posedge clk_i);
      mem_delay = 0;
      cur_tag   = "after_srst";
      run_walk(vec[1], 1'b1);

      repeat (3) @(negedge clk_i);
      check("end_scoreboard_empty", 64'(exp_q.size()), 64'd0);
      check("end_addr_q_empty",     64'(addr_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit reached");
   end

endmodule
